fletcher_checksum_mc: RTL and testbench
=======================================

// Module: fletcher_checksum_mc
// PURPOSE
//  Multi-channel streaming Fletcher checksum engine. Keeps up to Channels independent
//  (A,B) running sums mod 2^H-1 (H=Width/2), one data word per cycle with valid/ready.
//  On a last-flagged beat it emits {B,A}, word count and a match flag, then re-arms.
//  Sits between DMA/SD readout streams and the host link for per-stream integrity.
// PARAMETERS
//  Width     32  checksum width (16/32/64); data word H=Width/2 bits
//  Channels  4   independent accumulator sets (>=1)
//  CountW    16  result word-count width; saturates at all-ones
// PORTS
//  clk        in   1             clock
//  rst        in   1             synchronous active-high reset
//  in_valid   in   1             beat valid
//  in_ready   out  1             beat accepted when in_valid && in_ready
//  in_chan    in   clog2(Ch)     channel for this beat
//  in_data    in   H             data word
//  in_last    in   1             final word of the block; finalise channel
//  in_expect  in   Width         expected checksum, sampled with in_last beat
//  clr_en     in   1             clear channel clr_chan this cycle
//  clr_chan   in   clog2(Ch)     channel to clear
//  res_valid  out  1             result held until res_ready
//  res_ready  in   1             result consumer ready
//  res_chan   out  clog2(Ch)     channel of result
//  res_sum    out  Width         {B[H-1:0], A[H-1:0]}
//  res_count  out  CountW        words accumulated incl. last
//  res_match  out  1             res_sum == sampled in_expect
// BEHAVIOUR
//  - Reset: all A/B/count = 0; res_valid=0, res_sum=0, res_count=0, res_chan=0, res_match=0.
//  - M=2^H-1. A,B always fully reduced in [0,M-1]; value M never stored.
//  - Accepted beat on ch: A'=(A+d) mod M; B'=(B+A') mod M; count+1 (saturating).
//    Reduce via s=x+y (H+1 bits), s>=M ? s-M : s. d==M treated as 0. Single-cycle update.
//  - Back-to-back beats on the same channel legal every cycle; no bubbles, no forwarding stalls.
//  - in_ready = !res_valid || res_ready (combinational). Non-last beats also blocked
//    while a result is stalled (stream order preserved).
//  - Last beat: next cycle res_valid=1, res_sum={B',A'} incl. that word, res_chan=ch,
//    res_count=count', res_match=({B',A'}==in_expect); channel A/B/count -> 0 same edge.
//  - Result register: loaded on last beat; if res_ready && res_valid and no new last,
//    res_valid->0. Output fields hold stable while res_valid && !res_ready.
//  - Result handshake and new last beat in same cycle: old result retires, new loads; no gap.
//  - clr_en: channel A/B/count -> 0. Clear + accepted beat on same channel same cycle:
//    clear first, beat accumulates onto zero (beat becomes word 1). Different channels: both act.
//  - Clear of a channel does not affect a pending result already in res_*.
//  - Channel with zero words finalised only via last beat; empty block impossible.
//  - Reset mid-block or mid-handshake discards all sums and pending result immediately.
//  - in_chan >= Channels: beat accepted and dropped (no state change, no result).
// STRUCTURE
//  - Package fletcher_pkg: function mod_m_add(H), localparam ModM, result struct
//    {chan,sum,count,match}, chan index width helper.
//  - Sub-module fletcher_mod_add #(H): combinational x+y mod M; instanced for A and B.
//  - Top: per-channel A/B/count register arrays, update mux, result register; no FSM
//    beyond result valid bit.
// TESTING
//  - W=16, ch0 bytes "abcde" + last, expect 0xC8F0 -> res_sum=0xC8F0, count=5, match=1.
//  - W=16, ch1 "abcdef" interleaved beat-by-beat with ch0 "abcde" -> ch0 0xC8F0, ch1 0x2057.
//  - W=32, ch2 words 0x6261,0x6463,0x0065 + last -> res_sum=0xF04FC729, count=3.
//  - W=16, 300 beats of 0xFF on ch0 -> A,B stay 0, res_sum=0x0000; 0xFE words check wrap.
//  - res_ready=0 for 5 cycles after result -> in_ready=0, res_* stable; release -> next beat taken.
//  - clr_en+beat same ch mid-block, then rst mid-block -> sums restart; res_valid=0 after rst.

Source files
------------

// File: rtl/fletcher_pkg.sv
// Shared definitions for the multi-channel Fletcher checksum engine:
// modular adder arithmetic and channel index sizing.
package fletcher_pkg;

    // Widest supported half-word; covers a 64-bit checksum.
    localparam int MaxH = 32;

    // Index width for a channel count. It is never zero, so a single channel still has a port bit.
    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Sum of two fully reduced operands, taken mod 2^h-1. The result is never equal to 2^h-1.
    function automatic logic [MaxH-1:0] mod_m_add(input logic [MaxH-1:0] x,
                                                  input logic [MaxH-1:0] y,
                                                  input int              h);
        logic [MaxH:0] m;
        logic [MaxH:0] s;
        m = (MaxH+1)'((64'd1 << h) - 64'd1);
        s = {1'b0, x} + {1'b0, y};
        return (s >= m) ? MaxH'(s - m) : MaxH'(s);
    endfunction

endpackage

// File: rtl/fletcher_mod_add.sv
// Combinational x + y mod 2^H-1 for reduced H-bit operands; used for both the A and B sums.
module fletcher_mod_add
    import fletcher_pkg::*;
#(
    parameter int H = 16
) (
    input  logic [H-1:0] x,
    input  logic [H-1:0] y,
    output logic [H-1:0] s
);

    logic [MaxH-1:0] sum_wide;
    logic            unused_hi;

    assign sum_wide  = mod_m_add(MaxH'(x), MaxH'(y), H);
    assign s         = sum_wide[H-1:0];
    // The upper bits of the shared-width result are always zero.
    assign unused_hi = ^sum_wide;

endmodule

// File: rtl/fletcher_checksum_mc.sv
// Multi-channel streaming Fletcher checksum: per-channel (A,B) sums mod 2^H-1 and a single
// result register that holds {B,A}, the word count and the match flag until they are consumed.
module fletcher_checksum_mc
    import fletcher_pkg::*;
#(
    parameter int  Width    = 32,
    parameter int  Channels = 4,
    parameter int  CountW   = 16,
    localparam int H        = Width / 2,
    localparam int ChanW    = chan_w(Channels)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ChanW-1:0]  in_chan,
    input  logic [H-1:0]      in_data,
    input  logic              in_last,
    input  logic [Width-1:0]  in_expect,
    input  logic              clr_en,
    input  logic [ChanW-1:0]  clr_chan,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ChanW-1:0]  res_chan,
    output logic [Width-1:0]  res_sum,
    output logic [CountW-1:0] res_count,
    output logic              res_match
);

    localparam logic [H-1:0] ModM = '1;

    typedef struct packed {
        logic [ChanW-1:0]  chan;
        logic [Width-1:0]  sum;
        logic [CountW-1:0] count;
        logic              match;
    } res_t;

    logic [H-1:0]      a_q   [Channels];
    logic [H-1:0]      a_d   [Channels];
    logic [H-1:0]      b_q   [Channels];
    logic [H-1:0]      b_d   [Channels];
    logic [CountW-1:0] cnt_q [Channels];
    logic [CountW-1:0] cnt_d [Channels];
    res_t              res_q;
    res_t              res_d;
    logic              res_valid_q;
    logic              res_valid_d;

    logic              accept;
    logic              chan_ok;
    logic [H-1:0]      d_norm;
    logic [H-1:0]      a_cur;
    logic [H-1:0]      b_cur;
    logic [CountW-1:0] cnt_cur;
    logic [H-1:0]      a_new;
    logic [H-1:0]      b_new;
    logic [CountW-1:0] cnt_new;

    // A stalled result also blocks non-last beats, so stream order is preserved.
    assign in_ready = !res_valid_q || res_ready;
    assign accept   = in_valid && in_ready;
    assign d_norm   = (in_data == ModM) ? '0 : in_data;

    // Reads the addressed channel's sums. A clear in the same cycle makes the beat start from zero.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        chan_ok = 1'b0;
        a_cur   = '0;
        b_cur   = '0;
        cnt_cur = '0;
        for (int i = 0; i < Channels; i++) begin
            if (in_chan == ChanW'(i)) begin
                chan_ok = 1'b1;
                a_cur   = a_q[i];
                b_cur   = b_q[i];
                cnt_cur = cnt_q[i];
            end
        end
        if (clr_en && (clr_chan == in_chan)) begin
            a_cur   = '0;
            b_cur   = '0;
            cnt_cur = '0;
        end
    end

    assign cnt_new = (&cnt_cur) ? cnt_cur : cnt_cur + CountW'(1);

    fletcher_mod_add #(.H(H)) u_add_a (
        .x (a_cur),
        .y (d_norm),
        .s (a_new)
    );

    fletcher_mod_add #(.H(H)) u_add_b (
        .x (b_cur),
        .y (a_new),
        .s (b_new)
    );

    always_comb begin
        for (int i = 0; i < Channels; i++) begin
            a_d[i]   = a_q[i];
            b_d[i]   = b_q[i];
            cnt_d[i] = cnt_q[i];
            if (clr_en && (clr_chan == ChanW'(i))) begin
                a_d[i]   = '0;
                b_d[i]   = '0;
                cnt_d[i] = '0;
            end
            if (accept && (in_chan == ChanW'(i))) begin
                if (in_last) begin
                    a_d[i]   = '0;
                    b_d[i]   = '0;
                    cnt_d[i] = '0;
                end else begin
                    a_d[i]   = a_new;
                    b_d[i]   = b_new;
                    cnt_d[i] = cnt_new;
                end
            end
        end
    end

    // A new result takes priority over retiring the old one, so back-to-back results leave no gap.
    always_comb begin
        res_d       = res_q;
        res_valid_d = res_valid_q;
        if (accept && chan_ok && in_last) begin
            res_valid_d = 1'b1;
            res_d.chan  = in_chan;
            res_d.sum   = {b_new, a_new};
            res_d.count = cnt_new;
            res_d.match = ({b_new, a_new} == in_expect);
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments, so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: the per-channel sums are plain flops, not RAM, so resetting the whole array is legal.
            a_q         <= '{default: '0};
            b_q         <= '{default: '0};
            cnt_q       <= '{default: '0};
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_chan  = res_q.chan;
    assign res_sum   = res_q.sum;
    assign res_count = res_q.count;
    assign res_match = res_q.match;

endmodule

// File: tb/tb_fletcher_checksum_mc.sv
// Bench for fletcher_checksum_mc: 16-bit and 32-bit instances share one stimulus stream.
// A word-list reference model predicts every result and the handshake state on each cycle.
module tb_fletcher_checksum_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        clr_en = 1'b0;
    logic        res_ready = 1'b1;
    logic [1:0]  in_chan = '0;
    logic [1:0]  clr_chan = '0;
    logic [15:0] in_data = '0;
    logic [31:0] in_expect = '0;

    logic        in_ready16, res_valid16, res_match16;
    logic [1:0]  res_chan16;
    logic [15:0] res_sum16;
    logic [7:0]  res_count16;
    logic        in_ready32, res_valid32, res_match32;
    logic [1:0]  res_chan32;
    logic [31:0] res_sum32;
    logic [15:0] res_count32;

    logic        rand_rdy = 1'b0;
    logic        rdy_force = 1'b1;
    logic        mon_on = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fletcher_checksum_mc #(.Width(16), .Channels(3), .CountW(8)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_chan(in_chan),
        .in_data(in_data[7:0]), .in_last(in_last), .in_expect(in_expect[15:0]),
        .clr_en(clr_en), .clr_chan(clr_chan), .res_valid(res_valid16), .res_ready(res_ready),
        .res_chan(res_chan16), .res_sum(res_sum16), .res_count(res_count16), .res_match(res_match16)
    );

    fletcher_checksum_mc #(.Width(32), .Channels(3), .CountW(16)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in_chan(in_chan),
        .in_data(in_data), .in_last(in_last), .in_expect(in_expect),
        .clr_en(clr_en), .clr_chan(clr_chan), .res_valid(res_valid32), .res_ready(res_ready),
        .res_chan(res_chan32), .res_sum(res_sum32), .res_count(res_count32), .res_match(res_match32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Fletcher by definition: A = sum(d) mod M, B = sum((n-i)*d_i) mod M.
    function automatic longint unsigned fl(input int unsigned w[$], input int h);
        longint unsigned m, a, b, d;
        int n;
        m = (64'd1 << h) - 64'd1;
        a = 0;
        b = 0;
        n = w.size();
        for (int i = 0; i < n; i++) begin
            d = longint'(w[i]) & m;
            a += d;
            b += longint'(n - i) * d;
        end
        a %= m;
        b %= m;
        return (b << h) | a;
    endfunction

    typedef struct packed {
        logic [1:0]  chan;
        logic [15:0] sum16;
        logic [31:0] sum32;
        logic [7:0]  c16;
        logic [15:0] c32;
        logic        m16;
        logic        m32;
    } res_rec_t;

    // Reference model state: the words held per channel plus the expected result register.
    int unsigned     q [3][$];
    res_rec_t        got [$];
    logic            m_valid = 1'b0;
    logic [1:0]      m_chan = '0;
    logic [15:0]     m_sum16 = '0;
    logic [31:0]     m_sum32 = '0;
    logic [7:0]      m_c16 = '0;
    logic [15:0]     m_c32 = '0;
    logic            m_m16 = 1'b0;
    logic            m_m32 = 1'b0;
    logic            exp_rdy;
    logic            new_last;
    longint unsigned s16, s32;
    int              n;

    always @(posedge clk) begin
        #2;
        res_ready = rand_rdy ? ($urandom_range(0, 9) < 7) : rdy_force;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            exp_rdy = !m_valid || res_ready;
            check("in_ready16", in_ready16, exp_rdy);
            check("in_ready32", in_ready32, exp_rdy);
            check("res_valid16", res_valid16, m_valid);
            check("res_valid32", res_valid32, m_valid);
            check("res_chan16", res_chan16, m_chan);
            check("res_chan32", res_chan32, m_chan);
            check("res_sum16", res_sum16, m_sum16);
            check("res_sum32", res_sum32, m_sum32);
            check("res_count16", res_count16, m_c16);
            check("res_count32", res_count32, m_c32);
            check("res_match16", res_match16, m_m16);
            check("res_match32", res_match32, m_m32);
            if (!rst && m_valid && res_ready)
                got.push_back('{res_chan16, res_sum16, res_sum32, res_count16, res_count32,
                                res_match16, res_match32});
            if (rst) begin
                for (int c = 0; c < 3; c++) q[c].delete();
                m_valid = 1'b0; m_chan = '0; m_sum16 = '0; m_sum32 = '0;
                m_c16 = '0; m_c32 = '0; m_m16 = 1'b0; m_m32 = 1'b0;
            end else begin
                new_last = 1'b0;
                if (clr_en && clr_chan < 3) q[clr_chan].delete();
                if (in_valid && exp_rdy && in_chan < 3) begin
                    q[in_chan].push_back(32'(in_data));
                    if (in_last) begin
                        new_last = 1'b1;
                        n = q[in_chan].size();
                        s16 = fl(q[in_chan], 8);
                        s32 = fl(q[in_chan], 16);
                        m_chan  = in_chan;
                        m_sum16 = 16'(s16);
                        m_sum32 = 32'(s32);
                        m_c16   = (n > 255) ? 8'hFF : 8'(n);
                        m_c32   = (n > 65535) ? 16'hFFFF : 16'(n);
                        m_m16   = (16'(s16) == in_expect[15:0]);
                        m_m32   = (32'(s32) == in_expect);
                        q[in_chan].delete();
                    end
                end
                if (new_last) m_valid = 1'b1;
                else if (res_ready) m_valid = 1'b0;
            end
        end
    end

    task automatic send_wait();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready16) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("beat_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clr_en   = 1'b0;
    endtask

    task automatic beat(input int ch, input logic [15:0] d, input logic last,
                        input logic [31:0] exp, input logic clr, input int cc);
        in_valid  = 1'b1;
        in_chan   = 2'(ch);
        in_data   = d;
        in_last   = last;
        in_expect = exp;
        clr_en    = clr;
        clr_chan  = 2'(cc);
        send_wait();
    endtask

    task automatic get_res(output res_rec_t r);
        r = '0;
        for (int i = 0; i < 200 && got.size() == 0; i++) @(negedge clk);
        if (got.size() == 0) check("result_timeout", 1'b0, 1'b1);
        else r = got.pop_front();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  abc [6] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    logic [15:0] w32 [3] = '{16'h6261, 16'h6463, 16'h0065};

    initial begin
        res_rec_t r;
        int unsigned tq[$];
        int ch, cc, sel;
        logic [15:0] d;
        logic [31:0] ex;
        logic last, clr;

        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_res_valid", res_valid16, 1'b0);

        // ch0 "abcde", 16-bit checksum
        got.delete();
        for (int i = 0; i < 5; i++) beat(0, 16'(abc[i]), i == 4, 32'hC8F0, 1'b0, 0);
        get_res(r);
        check("abcde_sum16", r.sum16, 16'hC8F0);
        check("abcde_count16", r.c16, 8'd5);
        check("abcde_match16", r.m16, 1'b1);
        check("abcde_chan", r.chan, 2'd0);

        // ch1 "abcdef" interleaved with ch0 "abcde"
        got.delete();
        for (int i = 0; i < 5; i++) begin
            beat(1, 16'(abc[i]), 1'b0, 32'h0, 1'b0, 0);
            beat(0, 16'(abc[i]), i == 4, 32'hC8F0, 1'b0, 0);
        end
        beat(1, 16'(abc[5]), 1'b1, 32'h2057, 1'b0, 0);
        get_res(r);
        check("ilv_ch0_chan", r.chan, 2'd0);
        check("ilv_ch0_sum16", r.sum16, 16'hC8F0);
        get_res(r);
        check("ilv_ch1_chan", r.chan, 2'd1);
        check("ilv_ch1_sum16", r.sum16, 16'h2057);
        check("ilv_ch1_count16", r.c16, 8'd6);
        check("ilv_ch1_match16", r.m16, 1'b1);

        // ch2 16-bit words, 32-bit checksum
        got.delete();
        for (int i = 0; i < 3; i++) beat(2, w32[i], i == 2, 32'hF04FC729, 1'b0, 0);
        get_res(r);
        check("w32_sum32", r.sum32, 32'hF04FC729);
        check("w32_count32", r.c32, 16'd3);
        check("w32_match32", r.m32, 1'b1);

        // all-ones words equal M and reduce to zero; the 8-bit count saturates
        got.delete();
        for (int i = 0; i < 300; i++) beat(0, 16'hFFFF, i == 299, 32'h0, 1'b0, 0);
        get_res(r);
        check("ones_sum16", r.sum16, 16'h0000);
        check("ones_sum32", r.sum32, 32'h0);
        check("ones_count16_sat", r.c16, 8'hFF);
        check("ones_count32", r.c32, 16'd300);
        for (int i = 0; i < 12; i++) beat(0, 16'hFFFE, i == 11, 32'h0, 1'b0, 0);
        get_res(r);

        // result stall blocks new beats
        got.delete();
        rdy_force = 1'b0;
        beat(0, 16'h0061, 1'b1, 32'h6161, 1'b0, 0);
        in_valid = 1'b1; in_chan = 2'd1; in_data = 16'h0062; in_last = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready16", in_ready16, 1'b0);
        end
        rdy_force = 1'b1;
        send_wait();
        get_res(r);
        check("stall_sum16", r.sum16, 16'h6161);
        check("stall_count16", r.c16, 8'd1);
        check("stall_match16", r.m16, 1'b1);

        // a clear plus a beat on the same channel: the beat becomes word 1
        got.delete();
        beat(1, 16'h0061, 1'b0, 32'h0, 1'b0, 0);
        beat(1, 16'h0062, 1'b0, 32'h0, 1'b0, 0);
        beat(1, 16'h0063, 1'b0, 32'h0, 1'b1, 1);
        beat(1, 16'h0064, 1'b0, 32'h0, 1'b0, 0);
        beat(1, 16'h0065, 1'b1, 32'h582D, 1'b0, 0);
        get_res(r);
        check("clr_sum16", r.sum16, 16'h582D);
        check("clr_count16", r.c16, 8'd3);

        // a reset in the middle of a block and of a handshake
        got.delete();
        beat(2, 16'h0078, 1'b0, 32'h0, 1'b0, 0);
        rdy_force = 1'b0;
        beat(0, 16'h0061, 1'b1, 32'h0, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_res_valid16", res_valid16, 1'b0);
        check("rst_res_valid32", res_valid32, 1'b0);
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
        got.delete();
        for (int i = 0; i < 5; i++) beat(2, 16'(abc[i]), i == 4, 32'hC8F0, 1'b0, 0);
        get_res(r);
        check("post_rst_sum16", r.sum16, 16'hC8F0);
        check("post_rst_count16", r.c16, 8'd5);

        // an out-of-range channel is accepted and dropped
        got.delete();
        beat(3, 16'h0061, 1'b1, 32'h0, 1'b0, 0);
        repeat (4) @(negedge clk);
        check("oor_no_result", got.size(), 0);
        check("oor_res_valid16", res_valid16, 1'b0);
        @(posedge clk);
        #1;

        // random traffic checked against the model
        rand_rdy = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(posedge clk);
                #1;
            end
            ch = $urandom_range(0, 3);
            case ($urandom_range(0, 5))
                0:       d = 16'hFFFF;
                1:       d = 16'h00FF;
                2:       d = 16'hFFFE;
                default: d = 16'($urandom);
            endcase
            last = ($urandom_range(0, 7) == 0);
            clr  = ($urandom_range(0, 9) == 0);
            cc   = $urandom_range(0, 3);
            tq.delete();
            if (ch < 3) tq = q[ch];
            if (clr && cc == ch) tq.delete();
            tq.push_back(32'(d));
            sel = $urandom_range(0, 2);
            if (sel == 0)      ex = 32'(fl(tq, 16));
            else if (sel == 1) ex = {16'hABCD, 16'(fl(tq, 8))};
            else               ex = $urandom;
            beat(ch, d, last, ex, clr, cc);
        end
        rand_rdy  = 1'b0;
        rdy_force = 1'b1;
        repeat (10) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no summary, required finish before time limit");
        $fatal(1);
    end

endmodule
